// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO bank with a bus register file, 2-flop input sync,
// per-pin debounce, and edge-detect interrupt status.
module gpio_bank #(
  parameter int NPINS = 16,
  parameter int DBW   = 4
) (
  input  logic             pll_clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [4:0]       iomem_addr,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [NPINS-1:0] pad_in,
  output logic [NPINS-1:0] pad_out,
  output logic [NPINS-1:0] pad_oeb,
  output logic             irq
);

  localparam logic [2:0] REG_OUT      = 3'd0;
  localparam logic [2:0] REG_OEB      = 3'd1;
  localparam logic [2:0] REG_IN       = 3'd2;
  localparam logic [2:0] REG_RISE_EN  = 3'd3;
  localparam logic [2:0] REG_FALL_EN  = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;
  localparam logic [2:0] REG_DEBOUNCE = 3'd6;

  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [NPINS-1:0] r_out;
  logic [NPINS-1:0] r_oeb;
  logic [NPINS-1:0] r_rise_en;
  logic [NPINS-1:0] r_fall_en;
  logic [NPINS-1:0] r_status;
  logic [DBW-1:0]   r_deb;
  logic [NPINS-1:0] r_sync1;
  logic [NPINS-1:0] r_sync2;
  logic [NPINS-1:0] r_stable;
  logic [NPINS-1:0] r_stable_q;
  logic [DBW-1:0]   r_cnt [NPINS];

  logic             w_accept;
  logic             w_wr;
  logic [2:0]       w_sel;
  logic [31:0]      w_bytemask;
  logic [31:0]      w_out32;
  logic [31:0]      w_oeb32;
  logic [31:0]      w_in32;
  logic [31:0]      w_rise32;
  logic [31:0]      w_fall32;
  logic [31:0]      w_status32;
  logic [31:0]      w_deb32;
  logic [31:0]      w_out_m;
  logic [31:0]      w_oeb_m;
  logic [31:0]      w_rise_m;
  logic [31:0]      w_fall_m;
  logic [31:0]      w_deb_m;
  logic [31:0]      w_clr32;
  logic [31:0]      w_rd_mux;
  logic [NPINS-1:0] w_clr;
  logic [NPINS-1:0] w_set;
  logic             w_unused_ok;

  // A request is taken only while ready is low, so back-to-back requests
  // alternate accept / ready cycles.
  assign w_accept   = iomem_valid && !r_ready;
  assign w_wr       = w_accept && (iomem_wstrb != 4'b0000);
  assign w_sel      = iomem_addr[4:2];
  assign w_bytemask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                       {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  always_comb begin
    w_out32    = '0;
    w_oeb32    = '0;
    w_in32     = '0;
    w_rise32   = '0;
    w_fall32   = '0;
    w_status32 = '0;
    w_deb32    = '0;
    w_out32[NPINS-1:0]    = r_out;
    w_oeb32[NPINS-1:0]    = r_oeb;
    w_in32[NPINS-1:0]     = r_stable;
    w_rise32[NPINS-1:0]   = r_rise_en;
    w_fall32[NPINS-1:0]   = r_fall_en;
    w_status32[NPINS-1:0] = r_status;
    w_deb32[DBW-1:0]      = r_deb;
  end

  assign w_out_m  = (w_out32  & ~w_bytemask) | (iomem_wdata & w_bytemask);
  assign w_oeb_m  = (w_oeb32  & ~w_bytemask) | (iomem_wdata & w_bytemask);
  assign w_rise_m = (w_rise32 & ~w_bytemask) | (iomem_wdata & w_bytemask);
  assign w_fall_m = (w_fall32 & ~w_bytemask) | (iomem_wdata & w_bytemask);
  assign w_deb_m  = (w_deb32  & ~w_bytemask) | (iomem_wdata & w_bytemask);
  assign w_clr32  = iomem_wdata & w_bytemask;

  assign w_clr = (w_wr && (w_sel == REG_STATUS)) ? w_clr32[NPINS-1:0] : '0;
  assign w_set = (r_stable & ~r_stable_q & r_rise_en) |
                 (~r_stable & r_stable_q & r_fall_en);

  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      REG_OUT:      w_rd_mux = w_out32;
      REG_OEB:      w_rd_mux = w_oeb32;
      REG_IN:       w_rd_mux = w_in32;
      REG_RISE_EN:  w_rd_mux = w_rise32;
      REG_FALL_EN:  w_rd_mux = w_fall32;
      REG_STATUS:   w_rd_mux = w_status32;
      REG_DEBOUNCE: w_rd_mux = w_deb32;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && !w_wr) ? w_rd_mux : '0;
    end
  end

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      r_out     <= '0;
      r_oeb     <= '1;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_deb     <= '0;
    end else if (w_wr) begin
      case (w_sel)
        REG_OUT:      r_out     <= w_out_m[NPINS-1:0];
        REG_OEB:      r_oeb     <= w_oeb_m[NPINS-1:0];
        REG_RISE_EN:  r_rise_en <= w_rise_m[NPINS-1:0];
        REG_FALL_EN:  r_fall_en <= w_fall_m[NPINS-1:0];
        REG_DEBOUNCE: r_deb     <= w_deb_m[DBW-1:0];
        default:      ;
      endcase
    end
  end

  // A new edge event beats a simultaneous write-one-to-clear.
  always_ff @(posedge pll_clk) begin
    if (reset) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
    end else begin
      r_sync1    <= pad_in;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      for (int i = 0; i < NPINS; i++) begin
        if ((r_sync2[i] != r_stable[i]) && (r_cnt[i] >= r_deb)) begin
          r_stable[i] <= r_sync2[i];
        end
      end
    end
  end

  // The >= compare lets a lowered threshold take effect on counters already past it.
  always_ff @(posedge pll_clk) begin
    if (reset) begin
      for (int i = 0; i < NPINS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPINS; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= r_deb) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_unused_ok = ^{iomem_addr[1:0], w_out_m, w_oeb_m, w_rise_m,
                         w_fall_m, w_deb_m, w_clr32};

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign pad_out     = r_out;
  assign pad_oeb     = r_oeb;
  assign irq         = |r_status;

endmodule
